// File: rtl/arm_if_pkg.sv
// Shared definitions for the FPGA-to-ARM output bus: word width, arbiter
// state encoding and source identifiers.
package arm_if_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G_R3 = 2'd1,
        G_PP = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic SRC_R3 = 1'b0;
    localparam logic SRC_PP = 1'b1;

endpackage

// File: rtl/arm_out_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. rr_last remembers the previous winner so a
// tie always goes to the source that did not win last time.
module rr_arb2
    import arm_if_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic req_r3_i,
    input  logic req_pp_i,
    output logic gnt_valid_o,
    output logic gnt_src_o
);

    logic rr_last_q, rr_last_d;

    always_comb begin
        gnt_valid_o = en_i && (req_r3_i || req_pp_i);
        gnt_src_o   = SRC_R3;
        if (req_r3_i && req_pp_i) begin
            gnt_src_o = (rr_last_q == SRC_R3) ? SRC_PP : SRC_R3;
        end else if (req_pp_i) begin
            gnt_src_o = SRC_PP;
        end
        rr_last_d = gnt_valid_o ? gnt_src_o : rr_last_q;
    end

    // Reset to "ping-pong won last" so return3 takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= SRC_PP;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/arm_out_arbiter.sv
// Packet-atomic arbiter sharing the ARM output bus between the return3 and
// ping-pong RAM sources, with a one-word output slot, gap and stall timeout.
module arm_out_arbiter #(
    parameter int DW         = arm_if_pkg::DW,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    r3_data,
    input  logic             r3_valid,
    input  logic             r3_last,
    output logic             r3_ready,
    input  logic [DW-1:0]    pp_data,
    input  logic             pp_valid,
    input  logic             pp_last,
    output logic             pp_ready,
    output logic [DW-1:0]    data_to_arm,
    output logic             fpga_to_arm,
    input  logic             arm_rd_ack,
    output logic             cur_src,
    output logic [CNT_W-1:0] pkt_words,
    output logic             timeout_err
);

    import arm_if_pkg::*;

    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_END = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0]   GAP_END   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e         state_q, state_d;
    logic [DW-1:0]      data_q, data_d;
    logic               valid_q, valid_d;
    logic               src_q, src_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic               err_q, err_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    logic          slot_free;
    logic          gnt_valid, gnt_src;
    logic          sel_valid, sel_last, xfer;
    logic [DW-1:0] sel_data;

    // The slot can take a word when empty or when the ARM drains it this cycle.
    assign slot_free = !valid_q || arm_rd_ack;
    assign r3_ready  = (state_q == G_R3) && slot_free;
    assign pp_ready  = (state_q == G_PP) && slot_free;

    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q == IDLE),
        .req_r3_i   (r3_valid),
        .req_pp_i   (pp_valid),
        .gnt_valid_o(gnt_valid),
        .gnt_src_o  (gnt_src)
    );

    always_comb begin
        sel_valid = (state_q == G_PP) ? pp_valid : r3_valid;
        sel_last  = (state_q == G_PP) ? pp_last  : r3_last;
        sel_data  = (state_q == G_PP) ? pp_data  : r3_data;
        xfer      = (r3_valid && r3_ready) || (pp_valid && pp_ready);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        src_d   = src_q;
        words_d = words_q;
        err_d   = err_q;
        stall_d = stall_q;
        gap_d   = gap_q;

        if (xfer) begin
            data_d  = sel_data;
            valid_d = 1'b1;
            if (words_q != '1) begin
                words_d = words_q + 1'b1;
            end
        end else if (arm_rd_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = (gnt_src == SRC_PP) ? G_PP : G_R3;
                    src_d   = gnt_src;
                    words_d = '0;
                    stall_d = '0;
                end
            end
            G_R3, G_PP: begin
                if (sel_valid) begin
                    stall_d = '0;
                    if (xfer && sel_last) begin
                        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                        gap_d   = '0;
                    end
                end else if (stall_q == STALL_END) begin
                    // Abandon the stalled packet; a word already in the slot still drains.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_END) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= SRC_R3;
            words_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            words_q <= words_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            gap_q   <= gap_d;
        end
    end

    assign data_to_arm = data_q;
    assign fpga_to_arm = valid_q;
    assign cur_src     = src_q;
    assign pkt_words   = words_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_arm_out_arbiter.sv
// Self-checking bench for arm_out_arbiter: directed scenarios followed by a
// randomized phase, all checked against a packet-level model of the ARM stream.
module tb_arm_out_arbiter;

    localparam int TB_DW      = 16;
    localparam int TB_GAP     = 2;
    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 3;
    localparam int SAT        = (1 << TB_CNT_W) - 1;
    localparam int MAXP       = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [TB_DW-1:0]    r3_data, pp_data, data_to_arm;
    logic                r3_valid, r3_last, r3_ready;
    logic                pp_valid, pp_last, pp_ready;
    logic                fpga_to_arm, arm_rd_ack, cur_src, timeout_err;
    logic [TB_CNT_W-1:0] pkt_words;

    arm_out_arbiter #(
        .DW(TB_DW), .GAP_CYCLES(TB_GAP), .TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r3_data(r3_data), .r3_valid(r3_valid), .r3_last(r3_last), .r3_ready(r3_ready),
        .pp_data(pp_data), .pp_valid(pp_valid), .pp_last(pp_last), .pp_ready(pp_ready),
        .data_to_arm(data_to_arm), .fpga_to_arm(fpga_to_arm), .arm_rd_ack(arm_rd_ack),
        .cur_src(cur_src), .pkt_words(pkt_words), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int assertCount, failCount, cycleNo;
    int pSrc[MAXP], pBase[MAXP], pStep[MAXP], pLen[MAXP], pStart[MAXP], pAbandon[MAXP], pSent[MAXP];
    bit pDone[MAXP];
    int pCount;
    logic [15:0] expWords[$];
    int ackPct, dropPct, holdFrom, holdTo;
    int dropRun[2];
    bit pendFire;
    logic [15:0] pendWord;
    int pendSrc, pendWords;
    bit prevFpga, prevAck;
    logic [15:0] prevData;
    int fireCount, lastEndCycle, lastSpacing, errCycle;
    int lastFireCycle[2];
    bit prevEndedLast;
    int fireCycles[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int curPkt(input int s);
        for (int i = 0; i < pCount; i++) begin
            if (pSrc[i] == s && !pDone[i]) return i;
        end
        return -1;
    endfunction

    task automatic clearModel();
        pCount = 0;
        expWords.delete();
        fireCycles.delete();
        pendFire = 0;
        prevFpga = 0;
        prevAck = 0;
        prevData = '0;
        dropRun[0] = 0;
        dropRun[1] = 0;
        holdFrom = -1;
        holdTo = -1;
        prevEndedLast = 0;
        lastEndCycle = 0;
        errCycle = -1;
        lastFireCycle[0] = 0;
        lastFireCycle[1] = 0;
        fireCount = 0;
    endtask

    task automatic driveIdle();
        r3_valid = 0; r3_last = 0; r3_data = '0;
        pp_valid = 0; pp_last = 0; pp_data = '0;
        arm_rd_ack = 0;
    endtask

    task automatic addPacket(input int src, input int base, input int step, input int len,
                             input int startDelay, input int abandon);
        pSrc[pCount] = src;
        pBase[pCount] = base;
        pStep[pCount] = step;
        pLen[pCount] = len;
        pStart[pCount] = cycleNo + startDelay;
        pAbandon[pCount] = abandon;
        pSent[pCount] = 0;
        pDone[pCount] = 0;
        pCount++;
    endtask

    task automatic expectPacket(input int base, input int step, input int count);
        for (int i = 0; i < count; i++) expWords.push_back(16'(base + i * step));
    endtask

    // One clock cycle: drive producers and ARM ack, check the slot and stream, record transfers.
    task automatic applyStimulus();
        logic vv[2];
        logic ll[2];
        logic [15:0] dd[2];
        logic ack, rdy;
        logic [31:0] expWord;
        int k;
        @(negedge clk);
        cycleNo++;
        for (int s = 0; s < 2; s++) begin
            vv[s] = 0; ll[s] = 0; dd[s] = '0;
            k = curPkt(s);
            if (k >= 0 && cycleNo >= pStart[k] && (pAbandon[k] < 0 || pSent[k] < pAbandon[k])) begin
                dd[s] = 16'(pBase[k] + pSent[k] * pStep[k]);
                if (pSent[k] > 0 && dropRun[s] < 3 && $urandom_range(99) < dropPct) begin
                    dropRun[s]++;
                end else begin
                    vv[s] = 1;
                    dropRun[s] = 0;
                    ll[s] = (pSent[k] == pLen[k] - 1);
                end
            end
        end
        if (cycleNo >= holdFrom && cycleNo <= holdTo) ack = 0;
        else ack = ($urandom_range(99) < ackPct);
        r3_valid = vv[0]; r3_data = dd[0]; r3_last = ll[0];
        pp_valid = vv[1]; pp_data = dd[1]; pp_last = ll[1];
        arm_rd_ack = ack;
        #1;
        if (pendFire) begin
            checkOutput("xfer_valid", fpga_to_arm, 1);
            checkOutput("xfer_data", data_to_arm, pendWord);
            checkOutput("xfer_src", cur_src, pendSrc);
            checkOutput("xfer_count", pkt_words, pendWords);
            pendFire = 0;
        end else begin
            checkOutput("slot_state", fpga_to_arm, prevFpga && !prevAck);
            if (prevFpga && !prevAck) checkOutput("hold_data", data_to_arm, prevData);
        end
        if (fpga_to_arm && !ack) checkOutput("ready_when_full", {r3_ready, pp_ready}, 0);
        if (ack && fpga_to_arm) begin
            if (expWords.size() > 0) expWord = 32'(expWords.pop_front());
            else expWord = 'x;
            checkOutput("arm_word", data_to_arm, expWord);
        end
        for (int s = 0; s < 2; s++) begin
            rdy = (s == 0) ? r3_ready : pp_ready;
            if (vv[s] && rdy) begin
                k = curPkt(s);
                if (pSent[k] == 0) begin
                    if (prevEndedLast) begin
                        lastSpacing = cycleNo - lastEndCycle;
                        checkOutput("gap_spacing", lastSpacing >= TB_GAP + 2, 1);
                    end
                    prevEndedLast = 0;
                end
                pSent[k]++;
                pendFire = 1;
                pendWord = dd[s];
                pendSrc = s;
                pendWords = (pSent[k] > SAT) ? SAT : pSent[k];
                fireCount++;
                lastFireCycle[s] = cycleNo;
                fireCycles.push_back(cycleNo);
                if (ll[s]) begin
                    pDone[k] = 1;
                    prevEndedLast = 1;
                    lastEndCycle = cycleNo;
                end
            end
        end
        if (timeout_err && errCycle < 0) errCycle = cycleNo;
        prevFpga = fpga_to_arm;
        prevAck = ack;
        prevData = data_to_arm;
        @(posedge clk);
    endtask

    task automatic runUntilDone(input string tag, input int maxCycles);
        int n = 0;
        while (expWords.size() > 0 && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_done"}, expWords.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        driveIdle();
        clearModel();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int n;
        assertCount = 0;
        failCount = 0;
        cycleNo = 0;
        driveIdle();
        clearModel();
        ackPct = 100;
        dropPct = 0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_data", data_to_arm, 0);
        checkOutput("rst_valid", fpga_to_arm, 0);
        checkOutput("rst_r3_ready", r3_ready, 0);
        checkOutput("rst_pp_ready", pp_ready, 0);
        checkOutput("rst_cur_src", cur_src, 0);
        checkOutput("rst_pkt_words", pkt_words, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        rst_n = 1;

        $display("[TB] single return3 packet");
        addPacket(0, 'h0011, 'h0011, 3, 0, -1);
        addPacket(0, 'h0044, 1, 2, 0, -1);
        expectPacket('h0011, 'h0011, 3);
        expectPacket('h0044, 1, 2);
        runUntilDone("single", 60);
        checkOutput("single_back_to_back", fireCycles[2] - fireCycles[0], 2);
        checkOutput("single_gap", lastSpacing, TB_GAP + 2);

        $display("[TB] simultaneous requests from reset");
        doReset();
        addPacket(1, 'h0200, 1, 4, 0, -1);
        addPacket(0, 'h0300, 1, 2, 0, -1);
        addPacket(0, 'h0310, 1, 2, 0, -1);
        addPacket(1, 'h0210, 1, 3, 0, -1);
        expectPacket('h0300, 1, 2);
        expectPacket('h0200, 1, 4);
        expectPacket('h0310, 1, 2);
        expectPacket('h0210, 1, 3);
        runUntilDone("tie", 120);

        $display("[TB] backpressure during ping-pong burst");
        fireCount = 0;
        addPacket(1, 'h0100, 1, 8, 0, -1);
        expectPacket('h0100, 1, 8);
        n = 0;
        while (fireCount < 3 && n < 40) begin
            applyStimulus();
            n++;
        end
        holdFrom = cycleNo + 1;
        holdTo = cycleNo + 5;
        runUntilDone("backpressure", 80);
        checkOutput("bp_word_count", fireCount, 8);
        checkOutput("bp_saturated", pkt_words, SAT);

        $display("[TB] no interleave");
        addPacket(1, 'h0400, 1, 6, 0, -1);
        addPacket(0, 'h0500, 1, 3, 6, -1);
        expectPacket('h0400, 1, 6);
        expectPacket('h0500, 1, 3);
        runUntilDone("interleave", 80);

        $display("[TB] stall timeout");
        addPacket(1, 'h0600, 1, 5, 0, 2);
        addPacket(0, 'h0700, 1, 2, 4, -1);
        expectPacket('h0600, 1, 2);
        expectPacket('h0700, 1, 2);
        runUntilDone("timeout", 80);
        checkOutput("timeout_latency", errCycle - lastFireCycle[1], TB_TIMEOUT + 1);
        checkOutput("timeout_flag", timeout_err, 1);

        $display("[TB] async reset mid-transfer");
        fireCount = 0;
        addPacket(0, 'h0800, 1, 8, 0, -1);
        expectPacket('h0800, 1, 8);
        n = 0;
        while (fireCount < 3 && n < 40) begin
            applyStimulus();
            n++;
        end
        @(negedge clk);
        #2;
        checkOutput("pre_reset_busy", fpga_to_arm, 1);
        rst_n = 0;
        #1;
        checkOutput("arst_valid", fpga_to_arm, 0);
        checkOutput("arst_data", data_to_arm, 0);
        checkOutput("arst_timeout", timeout_err, 0);
        checkOutput("arst_r3_ready", r3_ready, 0);
        driveIdle();
        clearModel();
        repeat (2) @(negedge clk);
        rst_n = 1;
        addPacket(1, 'h0900, 1, 2, 0, -1);
        addPacket(0, 'h0A00, 1, 2, 0, -1);
        expectPacket('h0A00, 1, 2);
        expectPacket('h0900, 1, 2);
        runUntilDone("post_reset_tie", 60);

        $display("[TB] randomized traffic");
        ackPct = 60;
        dropPct = 25;
        for (int i = 0; i < 6; i++) begin
            int lenR3, lenPp;
            lenR3 = $urandom_range(6, 1);
            lenPp = $urandom_range(6, 1);
            addPacket(0, 'h1000 + i * 16, 1, lenR3, 0, -1);
            addPacket(1, 'h2000 + i * 16, 1, lenPp, 0, -1);
            expectPacket('h1000 + i * 16, 1, lenR3);
            expectPacket('h2000 + i * 16, 1, lenPp);
        end
        runUntilDone("random", 2000);
        ackPct = 100;
        dropPct = 0;
        repeat (8) applyStimulus();
        checkOutput("final_slot_empty", fpga_to_arm, 0);
        checkOutput("final_timeout", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
